mat_mult_sched: RTL and testbench
=================================

# mat_mult_sched

Address and control sequencer for the complex block-product datapath (Z^H·J and J^H·J over 512-sample split real/imag buffers). On a start pulse it walks every (row, column) output pair and every term index k. Each cycle it emits the four operand read addresses plus first/last accumulate markers. It also issues a delayed result-write strobe with the destination slot, so the MAC datapath becomes a pure pipeline with no internal counters.

## Interface
- N_ROW, 4, number of output rows
- N_COL, 4, number of output columns
- K_LEN, 64, terms per dot product
- IMAG_OFS, 256, buffer offset of imaginary half
- AW, 9, operand address width
- LAT, 2, cycles from an acc_last issue cycle to its accumulated result being valid in the datapath (1..7)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- start  input  1  begin a pass; sampled only in IDLE
- hold  input  1  freeze issue this cycle (operand source not ready)
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse at pass end
- addr_valid  output  1  operand addresses valid this cycle
- s_re_addr, s_im_addr  output  AW  row-operand real/imag address
- k_re_addr, k_im_addr  output  AW  column-operand real/imag address
- acc_first  output  1  first term of a pair (datapath clears accumulator)
- acc_last  output  1  last term of a pair
- res_we  output  1  result write strobe
- res_idx  output  4  result slot = row*N_COL + col (imag slot is res_idx+16 on the datapath side)

## Operation
- States: IDLE, RUN, DRAIN. All outputs are registered.
- Reset (rst=0 at an edge): state IDLE, row/col/k counters 0, delay pipe cleared, every output 0. Applies mid-pass: the pass is abandoned with no done and no further res_we.
- IDLE: if start=1, go to RUN with row=col=k=0 and busy=1. Otherwise all strobes stay 0.
- RUN, hold=0: drive addr_valid=1 with:
  - s_re = row*K_LEN + k
  - k_re = col*K_LEN + k
  - s_im = s_re + IMAG_OFS
  - k_im = k_re + IMAG_OFS
  - acc_first=(k==0), acc_last=(k==K_LEN-1)
  - Then advance k. On wrap of k advance col; on wrap of col advance row.
  - After issuing (N_ROW-1, N_COL-1, K_LEN-1), go to DRAIN.
- RUN, hold=1: addr_valid, acc_first and acc_last are 0. Counters and address outputs hold their values. The result delay pipe keeps shifting.
- Result pipe: an LAT-deep shift register of {valid, idx} is loaded on every acc_last issue. res_we/res_idx equal the pipe head. It is never stalled by hold.
- DRAIN: no issue. When the pipe is empty after the final res_we, pulse done=1, drop busy to 0 in the same cycle, and return to IDLE.
- start while busy=1 is ignored; no queuing.
- Address arithmetic: unsigned, AW bits. With the defaults the maximum is 255+256=511; no wrap is possible.

## Timing
- Cycle n means n edges after the edge that samples start=1 in IDLE.
- No hold: addr_valid=1 on cycles 1..1024. Pair p (0..15) issues on cycles 64p+1..64p+64, with acc_last on cycle 64p+64.
- res_we for pair p is on cycle 64p+64+LAT, with res_idx=p. The last res_we is on cycle 1024+LAT.
- done=1 on cycle 1025+LAT only. busy=1 on cycles 1..1024+LAT.
- Each cycle of hold=1 during RUN delays all subsequent issue, res_we and done by exactly one cycle.
- The earliest new start is accepted on the cycle done is high: the FSM is in IDLE from that cycle.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 -> every output 0 and no busy. Release -> IDLE.
- Full pass, hold=0, LAT=2 -> 1024 addr_valid cycles, 16 res_we on cycles 66,130,…,1026 with res_idx 0..15, done on cycle 1027 only.
- Address spot check: row=1, col=2, k=5 -> s_re=69, k_re=133, s_im=325, k_im=389. acc_first only when k=0, acc_last only when k=63.
- Hold 10 cycles starting at cycle 100 -> addresses frozen and addr_valid=0 during the hold. res_we for pair 0 stays on cycle 66. done moves to cycle 1037.
- start pulsed at cycle 500 of a running pass -> no effect, same done cycle. start on the done cycle -> new pass with addr_valid on the next cycle.
- rst=0 at cycle 300 -> all outputs 0 next cycle, no done, no later res_we. A following start runs a clean full pass.

Source files
------------

// File: rtl/mat_mult_sched.sv
// Operand address / accumulate-marker sequencer for the complex block-product MAC.
// Walks every (row, col, k) term, then emits delayed result-write strobes per output pair.
module mat_mult_sched #(
   parameter int N_ROW    = 4,
   parameter int N_COL    = 4,
   parameter int K_LEN    = 64,
   parameter int IMAG_OFS = 256,
   parameter int AW       = 9,
   parameter int LAT      = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hold,
   output logic          busy,
   output logic          done,
   output logic          addr_valid,
   output logic [AW-1:0] s_re_addr,
   output logic [AW-1:0] s_im_addr,
   output logic [AW-1:0] k_re_addr,
   output logic [AW-1:0] k_im_addr,
   output logic          acc_first,
   output logic          acc_last,
   output logic          res_we,
   output logic [3:0]    res_idx
);

   localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
   localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam int K_W   = (K_LEN > 1) ? $clog2(K_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [K_W-1:0]   k;

   logic k_wrap;
   logic col_wrap;
   logic row_wrap;
   logic issue;
   logic last_issue;

   logic [AW-1:0] s_re_calc;
   logic [AW-1:0] k_re_calc;
   logic [3:0]    idx_calc;

   logic [LAT-1:0] pipe_v;
   logic [3:0]     pipe_idx [LAT];
   logic           pipe_empty;

   logic          busy_n;
   logic          done_n;
   logic          addr_valid_n;
   logic          acc_first_n;
   logic          acc_last_n;
   logic [AW-1:0] s_re_n;
   logic [AW-1:0] s_im_n;
   logic [AW-1:0] k_re_n;
   logic [AW-1:0] k_im_n;
   logic          res_we_n;
   logic [3:0]    res_idx_n;

   assign k_wrap     = (k == K_W'(K_LEN - 1));
   assign col_wrap   = (col == COL_W'(N_COL - 1));
   assign row_wrap   = (row == ROW_W'(N_ROW - 1));
   assign issue      = (state == S_RUN) && !hold;
   assign last_issue = issue && k_wrap && col_wrap && row_wrap;
   assign pipe_empty = (pipe_v == '0);

   assign s_re_calc = AW'(row) * AW'(K_LEN) + AW'(k);
   assign k_re_calc = AW'(col) * AW'(K_LEN) + AW'(k);
   assign idx_calc  = 4'(32'(row) * 32'(N_COL) + 32'(col));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_RUN;
         S_RUN:   if (last_issue) next_state = S_DRAIN;
         S_DRAIN: if (pipe_empty) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // busy lags state entry by one edge so it covers exactly the issue and drain cycles
   always_comb begin
      busy_n       = (state != S_IDLE) && (next_state != S_IDLE);
      done_n       = (state == S_DRAIN) && (next_state == S_IDLE);
      addr_valid_n = issue;
      acc_first_n  = issue && (k == '0);
      acc_last_n   = issue && k_wrap;
      s_re_n       = s_re_addr;
      s_im_n       = s_im_addr;
      k_re_n       = k_re_addr;
      k_im_n       = k_im_addr;
      if (issue) begin
         s_re_n = s_re_calc;
         s_im_n = s_re_calc + AW'(IMAG_OFS);
         k_re_n = k_re_calc;
         k_im_n = k_re_calc + AW'(IMAG_OFS);
      end
      res_we_n  = pipe_v[LAT-1];
      res_idx_n = pipe_idx[LAT-1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row <= '0;
         col <= '0;
         k   <= '0;
      end else if (state == S_IDLE) begin
         row <= '0;
         col <= '0;
         k   <= '0;
      end else if (issue) begin
         if (k_wrap) begin
            k <= '0;
            if (col_wrap) begin
               col <= '0;
               row <= row_wrap ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end else begin
            k <= k + K_W'(1);
         end
      end
   end

   // Result pipe shifts every cycle, independent of hold, so write timing tracks issue only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pipe_v <= '0;
         for (int i = 0; i < LAT; i++) pipe_idx[i] <= '0;
      end else begin
         pipe_v[0]   <= issue && k_wrap;
         pipe_idx[0] <= idx_calc;
         for (int i = 1; i < LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         addr_valid <= 1'b0;
         acc_first  <= 1'b0;
         acc_last   <= 1'b0;
         s_re_addr  <= '0;
         s_im_addr  <= '0;
         k_re_addr  <= '0;
         k_im_addr  <= '0;
         res_we     <= 1'b0;
         res_idx    <= '0;
      end else begin
         busy       <= busy_n;
         done       <= done_n;
         addr_valid <= addr_valid_n;
         acc_first  <= acc_first_n;
         acc_last   <= acc_last_n;
         s_re_addr  <= s_re_n;
         s_im_addr  <= s_im_n;
         k_re_addr  <= k_re_n;
         k_im_addr  <= k_im_n;
         res_we     <= res_we_n;
         res_idx    <= res_idx_n;
      end
   end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Self-checking bench for mat_mult_sched: table of pass scenarios, a term-index
// reference model with an expected result-write queue, plus reset and abort sequences.
module tb_mat_mult_sched;

   localparam int N_ROW    = 4;
   localparam int N_COL    = 4;
   localparam int K_LEN    = 64;
   localparam int IMAG_OFS = 256;
   localparam int AW       = 9;
   localparam int LAT      = 2;
   localparam int TOTAL    = N_ROW * N_COL * K_LEN;
   localparam int NPAIR    = N_ROW * N_COL;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          hold = 1'b0;
   logic          busy;
   logic          done;
   logic          addr_valid;
   logic [AW-1:0] s_re_addr;
   logic [AW-1:0] s_im_addr;
   logic [AW-1:0] k_re_addr;
   logic [AW-1:0] k_im_addr;
   logic          acc_first;
   logic          acc_last;
   logic          res_we;
   logic [3:0]    res_idx;

   mat_mult_sched #(
      .N_ROW(N_ROW), .N_COL(N_COL), .K_LEN(K_LEN),
      .IMAG_OFS(IMAG_OFS), .AW(AW), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(busy), .done(done), .addr_valid(addr_valid),
      .s_re_addr(s_re_addr), .s_im_addr(s_im_addr),
      .k_re_addr(k_re_addr), .k_im_addr(k_im_addr),
      .acc_first(acc_first), .acc_last(acc_last),
      .res_we(res_we), .res_idx(res_idx)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   // {cycle[15:0], idx[3:0]} of each expected res_we
   logic [19:0] exp_q[$];

   typedef struct {
      int hold_start;
      int hold_len;
      bit rand_hold;
      int ign_start;
      bit spot;
      int exp_done;
   } pass_rec_t;

   pass_rec_t vec[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, addr_valid, acc_first, acc_last, res_we, res_idx,
                  s_re_addr, s_im_addr, k_re_addr, k_im_addr});
   endfunction

   // Drives one pass from a start pulse and checks every cycle against the term-index model.
   task automatic run_pass(input pass_rec_t r, output int done_cyc);
      int  issued, exp_done, cyc, i, erow, ecol, ek;
      int  es_re, es_im, ek_re, ek_im;
      int  n_av, n_af, n_al, n_we;
      bit  h, e_issue, run_now, e_we, finished;
      logic [3:0] e_idx;
      exp_q.delete();
      issued = 0; exp_done = -1; done_cyc = -1; finished = 0;
      n_av = 0; n_af = 0; n_al = 0; n_we = 0;
      es_re = 0; es_im = 0; ek_re = 0; ek_im = 0;
      start = 1'b1;
      hold  = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (cyc = 1; cyc < 4000; cyc++) begin
         h = ((cyc >= r.hold_start) && (cyc < r.hold_start + r.hold_len)) ||
             (r.rand_hold && ($urandom_range(0, 3) == 0));
         hold  = h;
         start = (cyc == r.ign_start);
         @(posedge clk);
         @(negedge clk);

         run_now = (issued < TOTAL);
         e_issue = run_now && !h;
         if (e_issue) begin
            i     = issued;
            erow  = i / (N_COL * K_LEN);
            ecol  = (i / K_LEN) % N_COL;
            ek    = i % K_LEN;
            es_re = erow * K_LEN + ek;
            ek_re = ecol * K_LEN + ek;
            es_im = es_re + IMAG_OFS;
            ek_im = ek_re + IMAG_OFS;
            if (ek == K_LEN - 1) exp_q.push_back({16'(cyc + LAT), 4'(erow * N_COL + ecol)});
            issued++;
            if (issued == TOTAL) exp_done = cyc + LAT + 1;
         end

         e_we  = 1'b0;
         e_idx = '0;
         if (exp_q.size() > 0 && exp_q[0][19:4] == 16'(cyc)) begin
            e_we  = 1'b1;
            e_idx = exp_q[0][3:0];
            void'(exp_q.pop_front());
         end

         check("ctrl", 64'({busy, done, addr_valid, acc_first, acc_last, res_we}),
               64'({(exp_done < 0) || (cyc < exp_done), cyc == exp_done, e_issue,
                    e_issue && (ek == 0), e_issue && (ek == K_LEN - 1), e_we}));
         if (e_we) check("res_idx", 64'(res_idx), 64'(e_idx));
         if (run_now && (e_issue || issued > 0))
            check(e_issue ? "addr" : "addr_held",
                  64'({s_re_addr, s_im_addr, k_re_addr, k_im_addr}),
                  64'({AW'(es_re), AW'(es_im), AW'(ek_re), AW'(ek_im)}));
         if (r.spot && cyc == 390) begin
            check("spot_s_re", 64'(s_re_addr), 64'(69));
            check("spot_k_re", 64'(k_re_addr), 64'(133));
            check("spot_s_im", 64'(s_im_addr), 64'(325));
            check("spot_k_im", 64'(k_im_addr), 64'(389));
         end

         n_av += int'(addr_valid);
         n_af += int'(acc_first);
         n_al += int'(acc_last);
         n_we += int'(res_we);
         if (done && done_cyc < 0) done_cyc = cyc;
         if (exp_done > 0 && cyc == exp_done) begin
            finished = 1'b1;
            break;
         end
      end
      hold  = 1'b0;
      start = 1'b0;
      if (!finished) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: pass did not complete, issued %0d of %0d", issued, TOTAL);
      end
      check("n_addr_valid", 64'(n_av), 64'(TOTAL));
      check("n_acc_first", 64'(n_af), 64'(NPAIR));
      check("n_acc_last", 64'(n_al), 64'(NPAIR));
      check("n_res_we", 64'(n_we), 64'(NPAIR));
      check("done_cycle_model", 64'(done_cyc), 64'(exp_done));
      if (r.exp_done > 0) check("done_cycle_table", 64'(done_cyc), 64'(r.exp_done));
   endtask

   // Starts a pass, resets it mid-flight and checks it stays silent afterwards.
   task automatic abort_pass(input int at);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c < at; c++) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs_zero", all_outs(), 64'(0));
      rst = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         @(negedge clk);
         check("abort_quiet", 64'({busy, done, addr_valid, res_we}), 64'(0));
      end
   endtask

   int dc;

   initial begin
      vec[0] = '{hold_start: 0,    hold_len: 0,  rand_hold: 0, ign_start: 0,   spot: 1, exp_done: 1027};
      vec[1] = '{hold_start: 100,  hold_len: 10, rand_hold: 0, ign_start: 500, spot: 0, exp_done: 1037};
      vec[2] = '{hold_start: 1,    hold_len: 1,  rand_hold: 0, ign_start: 0,   spot: 0, exp_done: 1028};
      vec[3] = '{hold_start: 1024, hold_len: 1,  rand_hold: 0, ign_start: 0,   spot: 0, exp_done: 1028};
      vec[4] = '{hold_start: 1025, hold_len: 6,  rand_hold: 0, ign_start: 0,   spot: 0, exp_done: 1027};
      vec[5] = '{hold_start: 0,    hold_len: 0,  rand_hold: 1, ign_start: 300, spot: 0, exp_done: -1};
      vec[6] = '{hold_start: 0,    hold_len: 0,  rand_hold: 1, ign_start: 0,   spot: 0, exp_done: -1};

      // reset held with start asserted
      rst   = 1'b0;
      start = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("reset_outputs_zero", all_outs(), 64'(0));
      end
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("idle_after_reset", 64'({busy, done, addr_valid, res_we}), 64'(0));
      end

      // consecutive passes: each new start lands on the previous done cycle
      for (int p = 0; p < 5; p++) run_pass(vec[p], dc);

      abort_pass(300);
      run_pass(vec[0], dc);
      run_pass(vec[5], dc);
      run_pass(vec[6], dc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
